// File: rtl/soc_key_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, per-key debounce FSM,
// clean level in raw pin polarity plus registered press/release pulses.
module soc_key_debouncer #(
   parameter int NUM_KEYS        = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key_raw,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_pressed,
   output logic [NUM_KEYS-1:0] key_released
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic PRESS_LVL = (ACTIVE_LOW == 0);
   localparam logic [NUM_KEYS-1:0] INACTIVE = {NUM_KEYS{ACTIVE_LOW != 0}};

   typedef enum logic {
      IDLE,
      CHECK
   } state_e;

   logic [NUM_KEYS-1:0] s1_q, s1_d;
   logic [NUM_KEYS-1:0] s2_q, s2_d;
   logic [NUM_KEYS-1:0] level_q, level_d;
   logic [NUM_KEYS-1:0] pressed_q, pressed_d;
   logic [NUM_KEYS-1:0] released_q, released_d;
   state_e              state_q [NUM_KEYS];
   state_e              state_d [NUM_KEYS];
   logic [CW-1:0]       cnt_q [NUM_KEYS];
   logic [CW-1:0]       cnt_d [NUM_KEYS];

   always_comb begin
      s1_d       = key_raw;
      s2_d       = s1_q;
      level_d    = level_q;
      pressed_d  = '0;
      released_d = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         state_d[k] = state_q[k];
         cnt_d[k]   = cnt_q[k];
         unique case (state_q[k])
            IDLE: begin
               cnt_d[k] = '0;
               if (s2_q[k] != level_q[k]) begin
                  state_d[k] = CHECK;
                  cnt_d[k]   = CW'(1);
               end
            end
            CHECK: begin
               if (s2_q[k] == level_q[k]) begin
                  state_d[k] = IDLE;
                  cnt_d[k]   = '0;
               end else if (cnt_q[k] == CNT_LAST) begin
                  // Sample held long enough: commit it and pulse once
                  state_d[k] = IDLE;
                  cnt_d[k]   = '0;
                  level_d[k] = s2_q[k];
                  if (s2_q[k] == PRESS_LVL) pressed_d[k] = 1'b1;
                  else released_d[k] = 1'b1;
               end else begin
                  cnt_d[k] = cnt_q[k] + 1'b1;
               end
            end
            default: begin
               state_d[k] = IDLE;
               cnt_d[k]   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q       <= INACTIVE;
         s2_q       <= INACTIVE;
         level_q    <= INACTIVE;
         pressed_q  <= '0;
         released_q <= '0;
         for (int k = 0; k < NUM_KEYS; k++) begin
            state_q[k] <= IDLE;
            cnt_q[k]   <= '0;
         end
      end else begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         level_q    <= level_d;
         pressed_q  <= pressed_d;
         released_q <= released_d;
         for (int k = 0; k < NUM_KEYS; k++) begin
            state_q[k] <= state_d[k];
            cnt_q[k]   <= cnt_d[k];
         end
      end
   end

   assign key_level    = level_q;
   assign key_pressed  = pressed_q;
   assign key_released = released_q;

endmodule

// File: tb/tb_soc_key_debouncer.sv
// Bench for soc_key_debouncer: sliding-window reference model checked
// every cycle, directed scenarios with literal expectations, random phase.
module tb_soc_key_debouncer;

   localparam int N = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] key_raw;
   logic [1:0] key_level;
   logic [1:0] key_pressed;
   logic [1:0] key_released;

   int ncomp = 0;
   int nfail = 0;
   int pc [2];
   int rc [2];

   always #5 clk = ~clk;

   soc_key_debouncer #(
      .NUM_KEYS(2),
      .DEBOUNCE_CYCLES(N),
      .ACTIVE_LOW(1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .key_raw(key_raw),
      .key_level(key_level),
      .key_pressed(key_pressed),
      .key_released(key_released)
   );

   task automatic chk(input string name, input logic [1:0] act,
                      input logic [1:0] exp);
      ncomp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp,
                  $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      ncomp++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp,
                  $time);
      end
   endtask

   task automatic clr();
      pc[0] = 0;
      pc[1] = 0;
      rc[0] = 0;
      rc[1] = 0;
   endtask

   // Model: level flips once the last N synchronised samples all differ from it
   bit         hist [2][$];
   logic [1:0] s1m, s2m, lvlm, expp, expr;

   always @(posedge clk) begin
      if (reset) begin
         s1m  = 2'b11;
         s2m  = 2'b11;
         lvlm = 2'b11;
         expp = 2'b00;
         expr = 2'b00;
         for (int k = 0; k < 2; k++) hist[k].delete();
      end else begin
         expp = 2'b00;
         expr = 2'b00;
         for (int k = 0; k < 2; k++) begin
            bit all_diff;
            hist[k].push_back(s2m[k]);
            if (hist[k].size() > N) void'(hist[k].pop_front());
            if (hist[k].size() == N) begin
               all_diff = 1'b1;
               for (int j = 0; j < N; j++)
                  if (hist[k][j] == lvlm[k]) all_diff = 1'b0;
               if (all_diff) begin
                  lvlm[k] = ~lvlm[k];
                  if (lvlm[k] == 1'b0) expp[k] = 1'b1;
                  else expr[k] = 1'b1;
               end
            end
         end
         s2m = s1m;
         s1m = key_raw;
      end
      #1;
      chk("model_level", key_level, lvlm);
      chk("model_pressed", key_pressed, expp);
      chk("model_released", key_released, expr);
      for (int k = 0; k < 2; k++) begin
         if (key_pressed[k]) pc[k]++;
         if (key_released[k]) rc[k]++;
      end
   end

   int hold [2];

   initial begin
      reset   = 1'b1;
      key_raw = 2'b11;
      clr();
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // 1: idle keys stay quiet
      repeat (50) @(negedge clk);
      chk_int("t1_pulses", pc[0] + pc[1] + rc[0] + rc[1], 0);
      chk("t1_level", key_level, 2'b11);

      // 2: clean press on key 0
      clr();
      key_raw = 2'b10;
      repeat (9) @(posedge clk);
      #2 chk("t2_before", key_level, 2'b11);
      @(posedge clk);
      #2 chk("t2_level", key_level, 2'b10);
      chk("t2_press", key_pressed, 2'b01);
      @(posedge clk);
      #2 chk("t2_pulse_end", key_pressed, 2'b00);

      // 3: bouncing key 0 then a clean hold
      @(negedge clk) key_raw = 2'b11;
      repeat (20) @(negedge clk);
      clr();
      for (int i = 0; i < 40; i++) begin
         key_raw[0] = ((i / 3) % 2) == 1;
         @(negedge clk);
      end
      key_raw[0] = 1'b0;
      repeat (9) @(posedge clk);
      #2 chk("t3_before", key_level, 2'b11);
      @(posedge clk);
      #2 chk("t3_level", key_level, 2'b10);
      repeat (20) @(negedge clk);
      chk_int("t3_press_cnt", pc[0], 1);
      chk_int("t3_rel_cnt", rc[0], 0);

      // 4: short glitch on key 1
      key_raw = 2'b11;
      repeat (20) @(negedge clk);
      clr();
      key_raw[1] = 1'b0;
      repeat (7) @(negedge clk);
      key_raw[1] = 1'b1;
      repeat (20) @(negedge clk);
      chk_int("t4_pulses", pc[1] + rc[1], 0);
      chk("t4_level", key_level, 2'b11);

      // 5: both keys together
      clr();
      key_raw = 2'b00;
      repeat (9) @(posedge clk);
      #2 chk("t5_before", key_level, 2'b11);
      @(posedge clk);
      #2 chk("t5_press", key_pressed, 2'b11);
      chk("t5_level", key_level, 2'b00);
      repeat (20) @(negedge clk);
      key_raw = 2'b11;
      repeat (9) @(posedge clk);
      #2 chk("t5_rel_before", key_released, 2'b00);
      @(posedge clk);
      #2 chk("t5_release", key_released, 2'b11);
      chk("t5_level_up", key_level, 2'b11);
      repeat (5) @(negedge clk);
      chk_int("t5_cnt", pc[0] + pc[1] + rc[0] + rc[1], 4);

      // 6: reset during CHECK, re-detect afterwards
      repeat (10) @(negedge clk);
      clr();
      key_raw = 2'b10;
      repeat (7) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      #1 chk("t6_rst_level", key_level, 2'b11);
      chk("t6_rst_press", key_pressed, 2'b00);
      @(negedge clk) reset = 1'b0;
      repeat (9) @(posedge clk);
      #2 chk("t6_before", key_level, 2'b11);
      @(posedge clk);
      #2 chk("t6_press", key_pressed, 2'b01);
      chk("t6_level", key_level, 2'b10);
      repeat (5) @(negedge clk);
      chk_int("t6_cnt", pc[0] + rc[0], 1);

      // Random bouncing with occasional resets
      hold[0] = 3;
      hold[1] = 5;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (hold[k] == 0) begin
               key_raw[k] = ~key_raw[k];
               hold[k] = (c % 400 < 200) ? $urandom_range(1, 12)
                                         : $urandom_range(1, 30);
            end else begin
               hold[k]--;
            end
         end
         reset = ($urandom_range(0, 299) == 0);
      end
      @(negedge clk) reset = 1'b0;
      key_raw = 2'b11;
      repeat (30) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp,
               nfail);
      $finish;
   end

endmodule
